// File: rtl/rv32im_exu_pkg.sv
// Shared definitions for the RV32IM execute unit: data and opcode widths,
// plus the ALU, LSU, branch, operand-origin and writeback-target encodings.
package rv32im_exu_pkg;

  localparam int API_DATA_WIDTH    = 32;
  localparam int ALU_OPCODE_WIDTH  = 5;
  localparam int LSU_OPCODE_WIDTH  = 4;
  localparam int BR_OPCODE_WIDTH   = 3;
  localparam int DATA_ORIGIN_WIDTH = 2;
  localparam int DATA_TARGET_WIDTH = 2;

  typedef logic [API_DATA_WIDTH-1:0] word_t;

  typedef enum logic [ALU_OPCODE_WIDTH-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [LSU_OPCODE_WIDTH-1:0] {
    LSU_NONE = 4'd0,
    LSU_LB   = 4'd1,
    LSU_LH   = 4'd2,
    LSU_LW   = 4'd3,
    LSU_LBU  = 4'd4,
    LSU_LHU  = 4'd5,
    LSU_SB   = 4'd6,
    LSU_SH   = 4'd7,
    LSU_SW   = 4'd8
  } lsu_op_e;

  typedef enum logic [BR_OPCODE_WIDTH-1:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6
  } br_op_e;

  typedef enum logic [DATA_ORIGIN_WIDTH-1:0] {
    ORIGIN_RS1_RS2  = 2'd0,
    ORIGIN_RS1_IMM  = 2'd1,
    ORIGIN_PC_IMM   = 2'd2,
    ORIGIN_ZERO_IMM = 2'd3
  } origin_e;

  typedef enum logic [DATA_TARGET_WIDTH-1:0] {
    TARGET_ALU  = 2'd0,
    TARGET_LOAD = 2'd1,
    TARGET_PC4  = 2'd2,
    TARGET_CSR  = 2'd3
  } target_e;

endpackage

// File: rtl/rv32im_exu_if.sv
// Operand/control bundle between the decode stage and the execute unit.
// master: decode side (drives operands and opcodes, reads results).
// slave : execute unit (reads operands, drives memory address/data, data_o, new_pc_o).
interface rv32im_exu_if;
  import rv32im_exu_pkg::*;

  logic [ALU_OPCODE_WIDTH-1:0]  alu_opcode_i;
  logic [LSU_OPCODE_WIDTH-1:0]  lsu_opcode_i;
  logic [BR_OPCODE_WIDTH-1:0]   br_opcode_i;
  word_t                        rs1_i;
  word_t                        rs2_i;
  word_t                        imm_i;
  logic [DATA_ORIGIN_WIDTH-1:0] data_origin_i;
  logic [DATA_TARGET_WIDTH-1:0] data_target_i;
  word_t                        val_memdatard_i;
  word_t                        val_memdatawr_o;
  word_t                        val_memaddr_o;
  logic                         is_branch_i;
  logic                         is_condition_i;
  word_t                        curr_pc_i;
  word_t                        new_pc_o;
  word_t                        csr_output_i;
  word_t                        data_o;

  modport master (
    output alu_opcode_i, lsu_opcode_i, br_opcode_i, rs1_i, rs2_i, imm_i,
           data_origin_i, data_target_i, val_memdatard_i, is_branch_i,
           is_condition_i, curr_pc_i, csr_output_i,
    input  val_memdatawr_o, val_memaddr_o, new_pc_o, data_o
  );

  modport slave (
    input  alu_opcode_i, lsu_opcode_i, br_opcode_i, rs1_i, rs2_i, imm_i,
           data_origin_i, data_target_i, val_memdatard_i, is_branch_i,
           is_condition_i, curr_pc_i, csr_output_i,
    output val_memdatawr_o, val_memaddr_o, new_pc_o, data_o
  );

endinterface

// File: rtl/rv32im_alu.sv
// Combinational RV32IM ALU (base integer ops plus M-extension multiply/divide).
// Ports: op (ALU opcode), a/b (operands), result (32-bit result; 0 for undefined op).
module rv32im_alu
  import rv32im_exu_pkg::*;
(
  input  logic [ALU_OPCODE_WIDTH-1:0] op,
  input  word_t                       a,
  input  word_t                       b,
  output word_t                       result
);

  logic [4:0]  shamt;
  logic        a_signed;
  logic        b_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic        div_zero;
  logic        div_ovf;
  word_t       quot_s;
  word_t       rem_s;
  word_t       quot_u;
  word_t       rem_u;

  assign shamt = b[4:0];

  // One 64x64 multiplier serves all four multiplies: operands are extended
  // according to the op's signedness, and the low 64 product bits are exact
  // for every mix. MUL's low half is the same whatever the extension.
  assign a_signed = (op == ALU_MULH) || (op == ALU_MULHSU);
  assign b_signed = (op == ALU_MULH);
  assign a_ext    = {{32{a_signed & a[31]}}, a};
  assign b_ext    = {{32{b_signed & b[31]}}, b};
  assign product  = a_ext * b_ext;

  // Divide-by-zero and the signed overflow case are resolved explicitly
  // below, so the raw quotient/remainder values are never used for them.
  assign div_zero = (b == '0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign quot_s   = $unsigned($signed(a) / $signed(b));
  assign rem_s    = $unsigned($signed(a) % $signed(b));
  assign quot_u   = a / b;
  assign rem_u    = a % b;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << shamt;
      ALU_SLT:    result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   result = {31'b0, a < b};
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_MUL:    result = product[31:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  result = product[63:32];
      ALU_DIV:    result = div_zero ? '1 : (div_ovf ? a : quot_s);
      ALU_DIVU:   result = div_zero ? '1 : quot_u;
      ALU_REM:    result = div_zero ? a  : (div_ovf ? '0 : rem_s);
      ALU_REMU:   result = div_zero ? a  : rem_u;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/rv32im_exu.sv
// RV32IM execute unit: operand selection, ALU, load/store formatting,
// branch resolution and the registered writeback / next-PC outputs.
// Ports: clk_i (clock), rst_i (synchronous active-high reset),
//        io (rv32im_exu_if.slave: operands and opcodes in; memory address,
//        store data, data_o and new_pc_o out).
// val_memaddr_o / val_memdatawr_o are combinational; data_o / new_pc_o are
// registered with one cycle of latency.
module rv32im_exu
  import rv32im_exu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  rv32im_exu_if.slave     io
);

  word_t       op_a;
  word_t       op_b;
  word_t       alu_result;
  word_t       mem_addr;
  word_t       store_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  word_t       load_data;
  logic        br_taken;
  word_t       pc_plus4;
  word_t       pc_plus_imm;
  word_t       next_pc;
  word_t       wb_data;
  word_t       data_q;
  word_t       pc_q;

  // Operand selection.
  always_comb begin
    op_a = io.rs1_i;
    op_b = io.rs2_i;
    case (io.data_origin_i)
      ORIGIN_RS1_RS2:  begin op_a = io.rs1_i;     op_b = io.rs2_i; end
      ORIGIN_RS1_IMM:  begin op_a = io.rs1_i;     op_b = io.imm_i; end
      ORIGIN_PC_IMM:   begin op_a = io.curr_pc_i; op_b = io.imm_i; end
      default:         begin op_a = '0;           op_b = io.imm_i; end
    endcase
  end

  rv32im_alu u_alu (
    .op     (io.alu_opcode_i),
    .a      (op_a),
    .b      (op_b),
    .result (alu_result)
  );

  // Memory address is always rs1+imm, independent of the operand mux.
  assign mem_addr         = io.rs1_i + io.imm_i;
  assign io.val_memaddr_o = mem_addr;

  // Store data is replicated across lanes so the memory only needs byte enables.
  always_comb begin
    store_data = '0;
    case (io.lsu_opcode_i)
      LSU_SB:  store_data = {4{io.rs2_i[7:0]}};
      LSU_SH:  store_data = {2{io.rs2_i[15:0]}};
      LSU_SW:  store_data = io.rs2_i;
      default: store_data = '0;
    endcase
  end
  assign io.val_memdatawr_o = store_data;

  // Load lane extraction from the aligned read word; misaligned halves
  // simply use addr[1] and are not trapped.
  always_comb begin
    byte_sel = io.val_memdatard_i[7:0];
    case (mem_addr[1:0])
      2'd0:    byte_sel = io.val_memdatard_i[7:0];
      2'd1:    byte_sel = io.val_memdatard_i[15:8];
      2'd2:    byte_sel = io.val_memdatard_i[23:16];
      default: byte_sel = io.val_memdatard_i[31:24];
    endcase
  end
  assign half_sel = mem_addr[1] ? io.val_memdatard_i[31:16] : io.val_memdatard_i[15:0];

  always_comb begin
    load_data = '0;
    case (io.lsu_opcode_i)
      LSU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LSU_LW:  load_data = io.val_memdatard_i;
      LSU_LBU: load_data = {24'b0, byte_sel};
      LSU_LHU: load_data = {16'b0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Branch condition always compares the register operands, not the ALU inputs.
  always_comb begin
    br_taken = 1'b0;
    case (io.br_opcode_i)
      BR_EQ:   br_taken = (io.rs1_i == io.rs2_i);
      BR_NE:   br_taken = (io.rs1_i != io.rs2_i);
      BR_LT:   br_taken = ($signed(io.rs1_i) <  $signed(io.rs2_i));
      BR_GE:   br_taken = ($signed(io.rs1_i) >= $signed(io.rs2_i));
      BR_LTU:  br_taken = (io.rs1_i <  io.rs2_i);
      BR_GEU:  br_taken = (io.rs1_i >= io.rs2_i);
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4    = io.curr_pc_i + 32'd4;
  assign pc_plus_imm = io.curr_pc_i + io.imm_i;

  // Unconditional transfers (JAL/JALR) take the ALU target with bit 0 cleared.
  always_comb begin
    next_pc = pc_plus4;
    if (io.is_branch_i) begin
      if (!io.is_condition_i) next_pc = alu_result & ~32'd1;
      else if (br_taken)      next_pc = pc_plus_imm;
      else                    next_pc = pc_plus4;
    end
  end

  always_comb begin
    wb_data = alu_result;
    case (io.data_target_i)
      TARGET_ALU:  wb_data = alu_result;
      TARGET_LOAD: wb_data = load_data;
      TARGET_PC4:  wb_data = pc_plus4;
      default:     wb_data = io.csr_output_i;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they were before the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      pc_q   <= '0;
    end else begin
      data_q <= wb_data;
      pc_q   <= next_pc;
    end
  end

  assign io.data_o   = data_q;
  assign io.new_pc_o = pc_q;

endmodule

// File: tb/tb_rv32im_exu.sv
// Self-checking bench for rv32im_exu: directed vectors for the documented
// cases plus randomized stimulus compared against a behavioural model.
module tb_rv32im_exu;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;

  rv32im_exu_if bus ();

  rv32im_exu dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic logic [31:0] ref_alu(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    int          t;
    longint      p;
    longint unsigned pu;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << b[4:0];
      3:  return (sa < sb) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> b[4:0];
      7:  begin t = sa >>> b[4:0]; return t; end
      8:  return a | b;
      9:  return a & b;
      10: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      11: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      12: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      13: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        t = sa / sb; return t;
      end
      15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        t = sa % sb; return t;
      end
      17: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model(output logic [31:0] e_addr, output logic [31:0] e_wr,
                       output logic [31:0] e_data, output logic [31:0] e_pc);
    logic [31:0] a, b, alu, sh, ld;
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    int   tmp;
    bit   taken;
    int   r1, r2;
    case (bus.data_origin_i)
      2'd0:    begin a = bus.rs1_i;     b = bus.rs2_i; end
      2'd1:    begin a = bus.rs1_i;     b = bus.imm_i; end
      2'd2:    begin a = bus.curr_pc_i; b = bus.imm_i; end
      default: begin a = 32'd0;         b = bus.imm_i; end
    endcase
    alu    = ref_alu(int'(bus.alu_opcode_i), a, b);
    e_addr = bus.rs1_i + bus.imm_i;
    case (bus.lsu_opcode_i)
      4'd6:    e_wr = {4{bus.rs2_i[7:0]}};
      4'd7:    e_wr = {2{bus.rs2_i[15:0]}};
      4'd8:    e_wr = bus.rs2_i;
      default: e_wr = 32'd0;
    endcase
    ld = 32'd0;
    sh = bus.val_memdatard_i >> (8 * e_addr[1:0]);
    case (bus.lsu_opcode_i)
      4'd1: begin s8 = sh[7:0]; tmp = s8; ld = tmp; end
      4'd2: begin sh = bus.val_memdatard_i >> (16 * e_addr[1]); s16 = sh[15:0]; tmp = s16; ld = tmp; end
      4'd3: ld = bus.val_memdatard_i;
      4'd4: ld = sh & 32'hFF;
      4'd5: begin sh = bus.val_memdatard_i >> (16 * e_addr[1]); ld = sh & 32'hFFFF; end
      default: ld = 32'd0;
    endcase
    r1 = $signed(bus.rs1_i);
    r2 = $signed(bus.rs2_i);
    case (bus.br_opcode_i)
      3'd1: taken = (bus.rs1_i == bus.rs2_i);
      3'd2: taken = (bus.rs1_i != bus.rs2_i);
      3'd3: taken = (r1 < r2);
      3'd4: taken = (r1 >= r2);
      3'd5: taken = (bus.rs1_i < bus.rs2_i);
      3'd6: taken = (bus.rs1_i >= bus.rs2_i);
      default: taken = 1'b0;
    endcase
    if (!bus.is_branch_i)         e_pc = bus.curr_pc_i + 4;
    else if (!bus.is_condition_i) e_pc = {alu[31:1], 1'b0};
    else if (taken)               e_pc = bus.curr_pc_i + bus.imm_i;
    else                          e_pc = bus.curr_pc_i + 4;
    case (bus.data_target_i)
      2'd0:    e_data = alu;
      2'd1:    e_data = ld;
      2'd2:    e_data = bus.curr_pc_i + 4;
      default: e_data = bus.csr_output_i;
    endcase
    if (rst) begin
      e_data = 32'd0;
      e_pc   = 32'd0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [4:0] alu, input logic [3:0] lsu, input logic [2:0] br,
                       input logic [1:0] org, input logic [1:0] tgt,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [31:0] mem, input logic [31:0] csr,
                       input logic isb, input logic isc);
    bus.alu_opcode_i    = alu;
    bus.lsu_opcode_i    = lsu;
    bus.br_opcode_i     = br;
    bus.data_origin_i   = org;
    bus.data_target_i   = tgt;
    bus.rs1_i           = rs1;
    bus.rs2_i           = rs2;
    bus.imm_i           = imm;
    bus.curr_pc_i       = pc;
    bus.val_memdatard_i = mem;
    bus.csr_output_i    = csr;
    bus.is_branch_i     = isb;
    bus.is_condition_i  = isc;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 64));
      default: return $urandom;
    endcase
  endfunction

  task automatic randomize_inputs();
    drive(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          pick_val(), pick_val(), pick_val(), $urandom, $urandom, $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Inputs are applied 1 time unit after a rising edge; combinational outputs
  // are checked 1 unit later, registered outputs 1 unit after the next edge.
  task automatic run_cycle(input string tag);
    logic [31:0] e_addr, e_wr, e_data, e_pc;
    #1;
    model(e_addr, e_wr, e_data, e_pc);
    check({tag, ".addr"}, bus.val_memaddr_o, e_addr);
    check({tag, ".wr"},   bus.val_memdatawr_o, e_wr);
    @(posedge clk);
    #1;
    check({tag, ".data"}, bus.data_o, e_data);
    check({tag, ".pc"},   bus.new_pc_o, e_pc);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst = 1'b1;
    drive(5'd0, 4'd0, 3'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset overrides arbitrary stimulus.
    drive(5'd0, 4'd0, 3'd0, 2'd0, 2'd3, 32'd6, 32'd100, 32'd8, 32'h1000, 32'd0, 32'h1234_5678, 1'b1, 1'b0);
    run_cycle("reset");
    check("reset_data_const", bus.data_o, 32'd0);
    check("reset_pc_const",   bus.new_pc_o, 32'd0);
    rst = 1'b0;

    // First edge after reset captures normally.
    drive(5'd0, 4'd0, 3'd0, 2'd0, 2'd0, 32'd6, 32'd100, 32'd0, 32'h1000, 32'd0, 32'd0, 1'b0, 1'b0);
    run_cycle("add");
    check("add_const",    bus.data_o, 32'd106);
    check("add_pc_const", bus.new_pc_o, 32'h1004);

    drive(5'd8, 4'd0, 3'd0, 2'd0, 2'd0, 32'd6, 32'd100, 32'd0, 32'h1004, 32'd0, 32'd0, 1'b0, 1'b0);
    run_cycle("or");
    check("or_const", bus.data_o, 32'd102);

    drive(5'd3, 4'd0, 3'd0, 2'd0, 2'd0, 32'd6, 32'd100, 32'd0, 32'h1008, 32'd0, 32'd0, 1'b0, 1'b0);
    run_cycle("slt");
    check("slt_const", bus.data_o, 32'd1);

    drive(5'd4, 4'd0, 3'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h100C, 32'd0, 32'd0, 1'b0, 1'b0);
    run_cycle("sltu");
    check("sltu_const", bus.data_o, 32'd0);

    drive(5'd7, 4'd0, 3'd0, 2'd0, 2'd0, 32'h8000_0000, 32'd4, 32'd0, 32'h1010, 32'd0, 32'd0, 1'b0, 1'b0);
    run_cycle("sra");
    check("sra_const", bus.data_o, 32'hF800_0000);

    drive(5'd14, 4'd0, 3'd0, 2'd0, 2'd0, 32'd7, 32'd0, 32'd0, 32'h1014, 32'd0, 32'd0, 1'b0, 1'b0);
    run_cycle("div0");
    check("div0_const", bus.data_o, 32'hFFFF_FFFF);

    drive(5'd16, 4'd0, 3'd0, 2'd0, 2'd0, 32'd7, 32'd0, 32'd0, 32'h1018, 32'd0, 32'd0, 1'b0, 1'b0);
    run_cycle("rem0");
    check("rem0_const", bus.data_o, 32'd7);

    drive(5'd14, 4'd0, 3'd0, 2'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h101C, 32'd0, 32'd0, 1'b0, 1'b0);
    run_cycle("divovf");
    check("divovf_const", bus.data_o, 32'h8000_0000);

    drive(5'd13, 4'd0, 3'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h1020, 32'd0, 32'd0, 1'b0, 1'b0);
    run_cycle("mulhu");
    check("mulhu_const", bus.data_o, 32'hFFFF_FFFE);

    drive(5'd0, 4'd1, 3'd0, 2'd1, 2'd1, 32'h100, 32'd0, 32'd3, 32'h1024, 32'h80FF_1234, 32'd0, 1'b0, 1'b0);
    #1;
    check("lb_addr_const", bus.val_memaddr_o, 32'h103);
    run_cycle("lb");
    check("lb_const", bus.data_o, 32'hFFFF_FF80);

    drive(5'd0, 4'd7, 3'd0, 2'd1, 2'd0, 32'h100, 32'h0000_ABCD, 32'd2, 32'h1028, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    check("sh_wr_const", bus.val_memdatawr_o, 32'hABCD_ABCD);
    run_cycle("sh");

    drive(5'd0, 4'd0, 3'd1, 2'd0, 2'd0, 32'd5, 32'd5, 32'h10, 32'h40, 32'd0, 32'd0, 1'b1, 1'b1);
    run_cycle("beq");
    check("beq_const", bus.new_pc_o, 32'h50);

    drive(5'd0, 4'd0, 3'd2, 2'd0, 2'd0, 32'd5, 32'd5, 32'h10, 32'h40, 32'd0, 32'd0, 1'b1, 1'b1);
    run_cycle("bne");
    check("bne_const", bus.new_pc_o, 32'h44);

    drive(5'd0, 4'd0, 3'd0, 2'd1, 2'd2, 32'h201, 32'd0, 32'd0, 32'h40, 32'd0, 32'd0, 1'b1, 1'b0);
    run_cycle("jalr");
    check("jalr_pc_const",   bus.new_pc_o, 32'h200);
    check("jalr_data_const", bus.data_o, 32'h44);

    // Randomized stimulus with occasional reset.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      randomize_inputs();
      run_cycle($sformatf("rnd%0d", i));
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/rv32im_exu.md
RV32IM_EXU -- requirements
Module: rv32im_exu

Interface
REQ-001 clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 rst_i  in  1  synchronous, active-high reset.
REQ-003 alu_opcode_i  in  ALU_OPCODE_WIDTH(5)  ALU operation select.
REQ-004 lsu_opcode_i  in  LSU_OPCODE_WIDTH(4)  load/store select.
REQ-005 br_opcode_i  in  BR_OPCODE_WIDTH(3)  branch compare select.
REQ-006 rs1_i, rs2_i, imm_i  in  32 each  register operands and immediate.
REQ-007 data_origin_i  in  DATA_ORIGIN_WIDTH(2)  operand source select.
REQ-008 data_target_i  in  DATA_TARGET_WIDTH(2)  writeback source select.
REQ-009 val_memdatard_i  in  32  aligned memory read word.
REQ-010 val_memdatawr_o  out  32  store data, lane-replicated.
REQ-011 val_memaddr_o  out  32  load/store byte address.
REQ-012 is_branch_i, is_condition_i  in  1 each  control-transfer flag; conditional flag.
REQ-013 curr_pc_i  in  32  current PC.
REQ-014 new_pc_o  out  32  next PC (registered).
REQ-015 csr_output_i  in  32  CSR read value.
REQ-016 data_o  out  32  writeback data (registered).

Function
REQ-017 Operands by data_origin: 00 A=rs1,B=rs2; 01 A=rs1,B=imm; 10 A=curr_pc,B=imm; 11 A=0,B=imm.
REQ-018 ALU codes 0..17: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; other codes -> 0.
REQ-019 Shifts use B[4:0]; SLT/SLTU produce 0 or 1; MUL low 32 bits; MULH* high 32 bits of 64-bit product with RV32M signedness.
REQ-020 Divide by zero: DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> A; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
REQ-021 val_memaddr_o = rs1+imm combinationally, always driven.
REQ-022 Stores (SB/SH/SW): val_memdatawr_o = {4{rs2[7:0]}} / {2{rs2[15:0]}} / rs2; all other LSU codes -> 0.
REQ-023 Loads: byte lane = addr[1:0], half lane = addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word; no misalignment trap.
REQ-024 LSU codes: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; undefined codes act as NONE.
REQ-025 Writeback select data_target: 00 ALU result, 01 load result, 10 curr_pc+4, 11 csr_output_i.
REQ-026 BR codes: 0 NONE, 1 EQ, 2 NE, 3 LT, 4 GE, 5 LTU, 6 GEU, comparing rs1 vs rs2; NONE/undefined -> not taken.
REQ-027 Next PC: is_branch=0 -> pc+4; is_branch=1,is_condition=0 -> ALU result with bit0 cleared (JAL/JALR); is_branch=1,is_condition=1 -> pc+imm if taken else pc+4.
REQ-028 All adds wrap modulo 2^32.
REQ-029 data_o and new_pc_o update on each rising edge from current inputs (1-cycle latency); memory outputs combinational (0 latency).

Reset
REQ-030 While rst_i high at a rising edge, data_o=0 and new_pc_o=0; reset overrides any simultaneous operation.
REQ-031 First post-reset edge captures normally; no other state exists.

Structure
REQ-032 Shared package/defines: API_DATA_WIDTH=32, all opcode widths, and ALU/LSU/BR/origin/target encodings.
REQ-033 One sub-module rv32im_alu (combinational ALU incl. M-extension); branch, LSU formatting, muxes and registers stay in rv32im_exu.

Verification
REQ-034 ADD, origin 00, target 00, rs1=6, rs2=100 -> data_o=106 next edge; new_pc_o=curr_pc+4.
REQ-035 OR rs1=6, rs2=100 -> 102; SLT -> 1; SLTU rs1=0xFFFFFFFF, rs2=1 -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-036 DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE.
REQ-037 LB rs1=0x100, imm=3, memdatard=0x80FF1234, target 01 -> addr 0x103, data_o=0xFFFFFF80; SH rs2=0xABCD -> wr=0xABCDABCD.
REQ-038 BEQ rs1=rs2, pc=0x40, imm=0x10 -> new_pc_o=0x50; BNE same -> 0x44; JALR rs1=0x201, imm=0, origin 01, target 10 -> new_pc 0x200, data_o=0x44.
REQ-039 rst_i high with any stimulus -> data_o=0, new_pc_o=0 at that edge.
